// File: rtl/hs32_execute_mc.sv
// hs32 execute stage: valid/ready on both sides, registered result and NZCV flags,
// and an iterative shift-add multiplier that holds the stage while it runs.
module hs32_execute_mc #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 4,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [RA_W-1:0]   rd_i,
    input  logic              we_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   d_o,
    output logic [RA_W-1:0]   rd_o,
    output logic              we_o,
    output logic [3:0]        flags_o,
    output logic              busy_o,
    output logic [RA_W-1:0]   rd3_o,
    output logic              illegal_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [RA_W-1:0]   mul_rd_q, mul_rd_d;
    logic              mul_we_q, mul_we_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   d_q, d_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic              we_q, we_d;
    logic [3:0]        flags_q, flags_d;
    logic              busy_q, busy_d;
    logic [RA_W-1:0]   rd3_q, rd3_d;
    logic              illegal_q, illegal_d;

    logic              fire_in_s;
    logic              fire_out_s;
    logic              out_free_s;
    logic              is_illegal_s;
    logic [XLEN+3:0]   alu_s;
    logic [XLEN-1:0]   acc_step_s;
    logic              load_s;
    logic [XLEN-1:0]   load_d_s;
    logic [RA_W-1:0]   load_rd_s;
    logic              load_we_s;
    logic [3:0]        load_flags_s;

    // Returns {N,Z,C,V,result}; C on SUB means "no borrow".
    function automatic logic [XLEN+3:0] alu_f(input logic [2:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN:0]   wide;
        logic [XLEN-1:0] res;
        logic            c;
        logic            v;
        wide = {(XLEN+1){1'b0}};
        res  = {XLEN{1'b0}};
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[XLEN-1:0];
                c    = wide[XLEN];
                v    = (a[XLEN-1] == b[XLEN-1]) && (res[XLEN-1] != a[XLEN-1]);
            end
            3'd1: begin
                wide = {1'b0, a} - {1'b0, b};
                res  = wide[XLEN-1:0];
                c    = ~wide[XLEN];
                v    = (a[XLEN-1] != b[XLEN-1]) && (res[XLEN-1] != a[XLEN-1]);
            end
            3'd2:    res = a & b;
            3'd3:    res = a | b;
            3'd4:    res = a ^ b;
            3'd5:    res = b;
            default: res = {XLEN{1'b0}};
        endcase
        return {res[XLEN-1], (res == {XLEN{1'b0}}), c, v, res};
    endfunction

    // Multiply result flags: only N and Z carry information.
    function automatic logic [3:0] nz_f(input logic [XLEN-1:0] res);
        return {res[XLEN-1], (res == {XLEN{1'b0}}), 2'b00};
    endfunction

    assign out_free_s   = ~valid_q | ready_i;
    assign ready_o      = (state_q == S_IDLE) & out_free_s & ~flush_i;
    assign fire_in_s    = valid_i & ready_o;
    assign fire_out_s   = valid_q & ready_i;
    assign is_illegal_s = (op_i == 3'd7) | ((op_i == 3'd6) & (MUL_EN == 0));
    assign alu_s        = alu_f(op_i, a_i, b_i);
    assign acc_step_s   = acc_q + (mplier_q[0] ? mcand_q : {XLEN{1'b0}});

    assign valid_o   = valid_q;
    assign d_o       = d_q;
    assign rd_o      = rd_q;
    assign we_o      = we_q;
    assign flags_o   = flags_q;
    assign busy_o    = busy_q;
    assign rd3_o     = rd3_q;
    assign illegal_o = illegal_q;

    // Next-state: accept/multiply sequencing, then output register and derived status.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        mul_rd_d     = mul_rd_q;
        mul_we_d     = mul_we_q;
        valid_d      = valid_q;
        d_d          = d_q;
        rd_d         = rd_q;
        we_d         = we_q;
        flags_d      = flags_q;
        illegal_d    = 1'b0;
        load_s       = 1'b0;
        load_d_s     = d_q;
        load_rd_s    = rd_q;
        load_we_s    = we_q;
        load_flags_s = flags_q;

        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = {CW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fire_in_s) begin
                        if (is_illegal_s) begin
                            illegal_d = 1'b1;
                        end else if (op_i == 3'd6) begin
                            // Bit 0 is folded in at accept so the product is ready after XLEN-1 more steps.
                            state_d  = S_MUL;
                            cnt_d    = CW'(XLEN-1);
                            acc_d    = b_i[0] ? a_i : {XLEN{1'b0}};
                            mcand_d  = {a_i[XLEN-2:0], 1'b0};
                            mplier_d = {1'b0, b_i[XLEN-1:1]};
                            mul_rd_d = rd_i;
                            mul_we_d = we_i;
                        end else begin
                            load_s       = 1'b1;
                            load_d_s     = alu_s[XLEN-1:0];
                            load_rd_s    = rd_i;
                            load_we_s    = we_i;
                            load_flags_s = alu_s[XLEN+3:XLEN];
                        end
                    end else begin
                        illegal_d = 1'b0;
                    end
                end
                S_MUL: begin
                    if (cnt_q != {CW{1'b0}}) begin
                        acc_d    = acc_step_s;
                        mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
                        mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                        cnt_d    = cnt_q - CW'(1);
                        if ((cnt_q == CW'(1)) && out_free_s) begin
                            state_d      = S_IDLE;
                            load_s       = 1'b1;
                            load_d_s     = acc_step_s;
                            load_rd_s    = mul_rd_q;
                            load_we_s    = mul_we_q;
                            load_flags_s = nz_f(acc_step_s);
                        end else begin
                            state_d = S_MUL;
                        end
                    end else if (out_free_s) begin
                        state_d      = S_IDLE;
                        load_s       = 1'b1;
                        load_d_s     = acc_q;
                        load_rd_s    = mul_rd_q;
                        load_we_s    = mul_we_q;
                        load_flags_s = nz_f(acc_q);
                    end else begin
                        state_d = S_MUL;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end

        if (flush_i) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else if (load_s) begin
            valid_d = 1'b1;
            d_d     = load_d_s;
            rd_d    = load_rd_s;
            we_d    = load_we_s;
            flags_d = load_flags_s;
        end else if (fire_out_s) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        busy_d = (state_d != S_IDLE) | valid_d;
        if (state_d == S_MUL) begin
            rd3_d = mul_rd_d;
        end else if (valid_d) begin
            rd3_d = rd_d;
        end else begin
            rd3_d = {RA_W{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            acc_q     <= {XLEN{1'b0}};
            mcand_q   <= {XLEN{1'b0}};
            mplier_q  <= {XLEN{1'b0}};
            mul_rd_q  <= {RA_W{1'b0}};
            mul_we_q  <= 1'b0;
            valid_q   <= 1'b0;
            d_q       <= {XLEN{1'b0}};
            rd_q      <= {RA_W{1'b0}};
            we_q      <= 1'b0;
            flags_q   <= 4'b0000;
            busy_q    <= 1'b0;
            rd3_q     <= {RA_W{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            mul_rd_q  <= mul_rd_d;
            mul_we_q  <= mul_we_d;
            valid_q   <= valid_d;
            d_q       <= d_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            flags_q   <= flags_d;
            busy_q    <= busy_d;
            rd3_q     <= rd3_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
